// File: rtl/chip8_top.sv
// chip8_top: FPGA top of the chip8 board project.
// Receives 8N1 RS-232 bytes on rs232_rx_i and shows the last good byte on led_o.
// Contains an oversample tick divider, a 2-FF input synchroniser and a UART receiver.
// Optional feature macro: FRAME_ERR_LED_EN -- when defined, a framing error shows 8'hFF
// on led_o until the next good byte; otherwise bad frames are dropped silently.
// Everything runs on ice_clk_i. rstn_i is asynchronous and active-high despite its name.
module chip8_top #(
   parameter int CLKS_PER_BIT = 96,  // ice_clk_i cycles per UART bit (multiple of SAMPLE_RATE)
   parameter int SAMPLE_RATE  = 16   // oversample ticks per bit (even, >= 8)
) (
   input  logic       ice_clk_i,
   input  logic       rstn_i,
   input  logic       rs232_rx_i,
   output logic [7:0] led_o
);

   localparam int DIV = CLKS_PER_BIT / SAMPLE_RATE;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW  = $clog2(SAMPLE_RATE);

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [TW-1:0] TC_HALF  = TW'(SAMPLE_RATE / 2 - 1);
   localparam logic [TW-1:0] TC_LAST  = TW'(SAMPLE_RATE - 1);

   // Receiver states: START waits half a bit so all later samples land on bit centres.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [1:0]    sync_q;
   logic          rx_s;
   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;
   logic          tick;
   state_t        state_q;
   logic [TW-1:0] tc_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic [7:0]    led_q;

   // Two-flop synchroniser on the asynchronous serial line; resets to idle-high.
   always_ff @(posedge ice_clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rs232_rx_i};
      end
   end

   assign rx_s = sync_q[1];

   // Divider next-state: free-running count that wraps at DIV-1.
   always_comb begin
      div_d = div_q + 1'b1;
      if (div_q == DIV_LAST) begin
         div_d = '0;
      end
   end

   // Divider register; the wrap cycle is the one-cycle oversample enable.
   always_ff @(posedge ice_clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign tick = (div_q == DIV_LAST);

   // Receiver FSM with registered LED output; advances only on oversample ticks.
   always_ff @(posedge ice_clk_i or posedge rstn_i) begin
      if (rstn_i) begin
         state_q <= S_IDLE;
         tc_q    <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         led_q   <= '0;
      end else if (tick) begin
         case (state_q)
            S_IDLE: begin
               tc_q  <= '0;
               idx_q <= '0;
               if (!rx_s) begin
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (tc_q == TC_HALF) begin
                  tc_q <= '0;
                  // A line back high at the start-bit centre was only a glitch.
                  state_q <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  tc_q <= tc_q + 1'b1;
               end
            end
            S_DATA: begin
               if (tc_q == TC_LAST) begin
                  tc_q           <= '0;
                  shift_q[idx_q] <= rx_s;
                  idx_q          <= idx_q + 1'b1;
                  if (idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end else begin
                  tc_q <= tc_q + 1'b1;
               end
            end
            S_STOP: begin
               if (tc_q == TC_LAST) begin
                  tc_q    <= '0;
                  idx_q   <= '0;
                  // Return to IDLE at the stop-bit centre so a back-to-back start is caught.
                  state_q <= S_IDLE;
                  if (rx_s) begin
                     led_q <= shift_q;
                  end else begin
`ifdef FRAME_ERR_LED_EN
                     led_q <= 8'hFF;
`else
                     led_q <= led_q;
`endif
                  end
               end else begin
                  tc_q <= tc_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               tc_q    <= '0;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign led_o = led_q;

endmodule

// File: tb/tb_chip8_top.sv
// tb_chip8_top: self-checking bench for chip8_top (UART receiver to LEDs).
// Frames are driven bit by bit on rs232_rx_i; the expected LED value for each frame is
// queued when the frame is driven and compared once the frame's stop bit has elapsed.
module tb_chip8_top;

   localparam int CPB = 96;
   localparam int SR  = 16;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] led;

   logic [7:0] exp_q[$];
   logic [7:0] led_model;
   int         total_cnt;
   int         bad_cnt;

   chip8_top #(
      .CLKS_PER_BIT(CPB),
      .SAMPLE_RATE (SR)
   ) dut (
      .ice_clk_i (clk),
      .rstn_i    (rst),
      .rs232_rx_i(rx),
      .led_o     (led)
   );

   // Clock: 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
      end
   endtask

   // Drive one bit for a full bit time, changing rx on the falling edge.
   task automatic drive_bit(input logic b);
      @(negedge clk);
      rx = b;
      repeat (CPB - 1) @(negedge clk);
   endtask

   // Drive a complete 8N1 frame with a selectable stop-bit level.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_bit);
   endtask

   // Good frame: the LED model takes the byte; queue the expectation, then drive.
   task automatic send_good(input logic [7:0] d);
      led_model = d;
      exp_q.push_back(led_model);
      send_frame(d, 1'b1);
   endtask

   // Framing-error frame: LED expectation depends on the configured error behaviour.
   task automatic send_bad(input logic [7:0] d);
`ifdef FRAME_ERR_LED_EN
      led_model = 8'hFF;
`endif
      exp_q.push_back(led_model);
      send_frame(d, 1'b0);
   endtask

   // Pop the oldest expectation and compare it with the LED output.
   task automatic pop_check(input string tag);
      if (exp_q.size() == 0) begin
         total_cnt++;
         bad_cnt++;
         $display("FAIL %s: got=%02h expected=<empty queue>", tag, led);
      end else begin
         check_eq(tag, led, exp_q.pop_front());
      end
   endtask

   task automatic idle_bits(input int n);
      @(negedge clk);
      rx = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      led_model = 8'h00;
   endtask

   initial begin
      logic [7:0] r;
      total_cnt = 0;
      bad_cnt   = 0;
      rst       = 1'b1;
      rx        = 1'b1;
      led_model = 8'h00;

      // Reset and idle line: LED stays at zero.
      repeat (10) @(negedge clk);
      check_eq("reset_led", led, 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         repeat (CPB * 2) @(negedge clk);
         check_eq("idle_led", led, 8'h00);
      end

      // Single frame.
      send_good(8'h48);
      pop_check("single_48");
      idle_bits(2);

      // Back-to-back stream with no idle gap between frames.
      for (int i = 0; i < 3; i++) begin
         send_good(8'h48);
         pop_check("stream_48");
         send_good(8'h1D);
         pop_check("stream_1D");
      end
      idle_bits(2);

      // Short low glitch on an idle line: rejected in START.
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx = 1'b1;
      repeat (CPB * 3) @(negedge clk);
      check_eq("glitch_reject", led, led_model);

      // Framing error on 0x55.
      send_bad(8'h55);
      idle_bits(1);
      pop_check("frame_err_55");
      idle_bits(1);

      // Random good bytes.
      for (int i = 0; i < 4; i++) begin
         r = 8'($urandom_range(0, 255));
         send_good(r);
         pop_check("random_byte");
         idle_bits(1);
      end

      // Reset in the middle of data bit 4 of 0x1D.
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(r[i] ^ r[i] ^ ((8'h1D >> i) & 1'b1));
      @(negedge clk);
      rx = 1'b1;  // bit 4 of 0x1D is 1
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("reset_midframe", led, 8'h00);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      led_model = 8'h00;
      idle_bits(1);
      check_eq("after_reset", led, 8'h00);

      send_good(8'h48);
      pop_check("post_reset_48");
      idle_bits(1);

      // Reset again, then confirm the LED is cleared and a new byte is taken.
      do_reset();
      check_eq("reset_again", led, 8'h00);
      send_good(8'hA5);
      pop_check("final_A5");

      if (exp_q.size() != 0) begin
         total_cnt++;
         bad_cnt++;
         $display("FAIL leftover_queue: got=%0d expected=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
